mac_vector_sequencer: RTL and testbench
=======================================

// Module: mac_vector_sequencer
// PURPOSE
//  Upstream feeder for the signed MAC. Buffers one vector of VEC_LEN (a,b) operand pairs
//  from a valid/ready stream, clears the MAC, then issues the pairs back-to-back.
//  After the MAC pipeline drains, it captures the dot product and presents it on a
//  valid/ready result port. Sits between the operand source (weight/activation fetch)
//  and one mac instance.
// PARAMETERS
//  DATA_W   8  width of a, b, mac_out and res_data (signed two's complement)
//  VEC_LEN  4  pairs per dot product, >=2
//  MAC_LAT  1  cycles from last mac_enable edge to valid mac_out, >=1
// PORTS
//  clk         in   1       clock, all state updates on rising edge
//  reset       in   1       asynchronous, active-low reset
//  in_valid    in   1       operand pair valid
//  in_ready    out  1       sequencer accepts a pair this cycle
//  in_a        in   DATA_W  signed operand a
//  in_b        in   DATA_W  signed operand b
//  mac_reset   out  1       active-high clear to MAC accumulator
//  mac_enable  out  1       MAC accumulate strobe
//  mac_a       out  DATA_W  operand a to MAC
//  mac_b       out  DATA_W  operand b to MAC
//  mac_out     in   DATA_W  MAC accumulator value
//  res_valid   out  1       dot-product result valid
//  res_ready   in   1       consumer accepts result
//  res_data    out  DATA_W  signed dot product (MAC width, wraps as MAC wraps)
//  busy        out  1       high in every state except S_LOAD
// BEHAVIOUR
//  - Reset (reset==0, any time, incl. mid-vector): state=S_CLEAR, counters=0,
//    in_ready=0, mac_enable=0, mac_reset=0, mac_a=mac_b=0, res_valid=0,
//    res_data=0, busy=1. Buffered pairs are discarded.
//  - All outputs are registered; in_ready is decoded from the state register.
//  - S_CLEAR: mac_reset=1 for exactly 1 cycle; next state is S_LOAD.
//  - S_LOAD: in_ready=1.
//    - Each cycle with in_valid&&in_ready writes buf[cnt] and increments cnt.
//    - Gaps with in_valid=0 stall without loss.
//    - The accept at cnt==VEC_LEN-1 sets cnt=0 and moves to S_RUN.
//    - in_ready is 0 the cycle after the last accept; no pair is accepted outside S_LOAD.
//  - S_RUN: exactly VEC_LEN consecutive cycles with mac_enable=1 and
//    mac_a/mac_b = buf[k], k=0..VEC_LEN-1 in acceptance order. Next state is S_DRAIN.
//  - S_DRAIN: mac_enable=0, mac_a=mac_b=0. Waits MAC_LAT cycles, then samples
//    res_data<=mac_out and moves to S_OUT.
//  - S_OUT: res_valid=1; res_data is held stable while res_ready=0.
//    - res_valid&&res_ready moves to S_CLEAR; res_valid=0 next cycle.
//  - Latency: the first S_RUN cycle follows the last accept; res_valid rises
//    VEC_LEN+MAC_LAT+1 cycles after the first S_RUN cycle.
//  - Arithmetic: no widening or saturation here; res_data is the MAC's DATA_W
//    wrap-around result, bit-exact.
//  - mac_reset and mac_enable are never both 1.
//  - Back-pressure: a vector is not accepted while a result is pending; next vector
//    load starts 2 cycles after the result handshake (S_CLEAR, then S_LOAD).
// TESTING
//  T1 basic: pairs (1,5)(4,10)(12,2)(2,3), res_ready=1 -> res_data=75, one res_valid pulse.
//  T2 signed: (1,-1)(-1,1)(-1,-2)(-20,2) -> res_data=-40; next vector (-7,-2)(0,0)(0,0)(0,0) -> 14
//     (MAC cleared between vectors).
//  T3 wrap: (127,2)(1,1)(0,0)(0,0) -> res_data=8'hFF (-1); mac_enable high exactly 4 cycles.
//  T4 stalls: in_valid toggled 1,0,0,1,0,1,1 over 4 pairs of T1; res_ready low 5 cycles ->
//     res_data=75 held stable, in_ready=0 throughout, single handshake.
//  T5 reset mid-run: drop reset during 2nd S_RUN cycle -> all outputs 0 async, busy=1;
//     after release mac_reset pulses once; T1 vector then yields 75 (no stale pairs).
//  T6 protocol checkers: no accept outside S_LOAD; mac_reset&&mac_enable never true;
//     res_data stable while res_valid&&!res_ready.

Source files
------------

// File: rtl/mac_vector_sequencer.sv
// Operand buffer and issue sequencer for a signed MAC: loads VEC_LEN (a,b) pairs, clears the MAC,
// streams the pairs back-to-back, waits out the MAC latency and hands off the dot product.
module mac_vector_sequencer #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned VEC_LEN = 4,
    parameter int unsigned MAC_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic              mac_reset,
    output logic              mac_enable,
    output logic [DATA_W-1:0] mac_a,
    output logic [DATA_W-1:0] mac_b,
    input  logic [DATA_W-1:0] mac_out,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              busy
);

    localparam int unsigned IDX_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
    localparam int unsigned CNT_W = $clog2(VEC_LEN + MAC_LAT + 1);

    localparam logic [2:0] S_CLEAR = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_OUT   = 3'd4;

    logic [2:0]        state_q,      state_d;
    logic [CNT_W-1:0]  cnt_q,        cnt_d;
    logic              mac_reset_q,  mac_reset_d;
    logic              mac_enable_q, mac_enable_d;
    logic [DATA_W-1:0] mac_a_q,      mac_a_d;
    logic [DATA_W-1:0] mac_b_q,      mac_b_d;
    logic              res_valid_q,  res_valid_d;
    logic [DATA_W-1:0] res_data_q,   res_data_d;

    logic [DATA_W-1:0] buf_a_q [VEC_LEN];
    logic [DATA_W-1:0] buf_b_q [VEC_LEN];

    logic              buf_we_c;
    logic [IDX_W-1:0]  wr_idx_c;
    logic [IDX_W-1:0]  rd_idx_c;

    assign wr_idx_c = cnt_q[IDX_W-1:0];
    assign rd_idx_c = IDX_W'(cnt_q + CNT_W'(1));

    // Next-state and registered-output decode
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        mac_reset_d  = 1'b0;
        mac_enable_d = 1'b0;
        mac_a_d      = '0;
        mac_b_d      = '0;
        res_valid_d  = res_valid_q;
        res_data_d   = res_data_q;
        buf_we_c     = 1'b0;

        case (state_q)
            S_CLEAR: begin
                // Pulse is raised on entry from reset, so both paths see exactly one cycle
                if (mac_reset_q) begin
                    state_d = S_LOAD;
                end else begin
                    mac_reset_d = 1'b1;
                end
            end
            S_LOAD: begin
                if (in_valid) begin
                    buf_we_c = 1'b1;
                    if (cnt_q == CNT_W'(VEC_LEN - 1)) begin
                        cnt_d        = '0;
                        state_d      = S_RUN;
                        mac_enable_d = 1'b1;
                        mac_a_d      = buf_a_q[0];
                        mac_b_d      = buf_b_q[0];
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_RUN: begin
                if (cnt_q == CNT_W'(VEC_LEN - 1)) begin
                    cnt_d   = '0;
                    state_d = S_DRAIN;
                end else begin
                    cnt_d        = cnt_q + CNT_W'(1);
                    mac_enable_d = 1'b1;
                    mac_a_d      = buf_a_q[rd_idx_c];
                    mac_b_d      = buf_b_q[rd_idx_c];
                end
            end
            S_DRAIN: begin
                if (cnt_q == CNT_W'(MAC_LAT)) begin
                    cnt_d       = '0;
                    res_data_d  = mac_out;
                    res_valid_d = 1'b1;
                    state_d     = S_OUT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_OUT: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    mac_reset_d = 1'b1;
                    state_d     = S_CLEAR;
                end
            end
            default: begin
                state_d = S_CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_CLEAR;
            cnt_q        <= '0;
            mac_reset_q  <= 1'b0;
            mac_enable_q <= 1'b0;
            mac_a_q      <= '0;
            mac_b_q      <= '0;
            res_valid_q  <= 1'b0;
            res_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mac_reset_q  <= mac_reset_d;
            mac_enable_q <= mac_enable_d;
            mac_a_q      <= mac_a_d;
            mac_b_q      <= mac_b_d;
            res_valid_q  <= res_valid_d;
            res_data_q   <= res_data_d;
        end
    end

    // Operand buffer; contents are always rewritten before being issued
    always_ff @(posedge clk) begin
        if (buf_we_c) begin
            buf_a_q[wr_idx_c] <= in_a;
            buf_b_q[wr_idx_c] <= in_b;
        end
    end

    assign in_ready   = (state_q == S_LOAD);
    assign busy       = (state_q != S_LOAD);
    assign mac_reset  = mac_reset_q;
    assign mac_enable = mac_enable_q;
    assign mac_a      = mac_a_q;
    assign mac_b      = mac_b_q;
    assign res_valid  = res_valid_q;
    assign res_data   = res_data_q;

endmodule

// File: tb/tb_mac_vector_sequencer.sv
// Bench for mac_vector_sequencer: a behavioural signed MAC closes the loop and dot products
// are predicted from plain integer arithmetic over each vector.
module tb_mac_vector_sequencer;

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned VEC_LEN = 4;
    localparam int unsigned MAC_LAT = 1;
    localparam int          VL      = 4;
    localparam int          LAT     = 6;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_a = '0;
    logic [DATA_W-1:0] in_b = '0;
    logic              mac_reset;
    logic              mac_enable;
    logic [DATA_W-1:0] mac_a;
    logic [DATA_W-1:0] mac_b;
    logic [DATA_W-1:0] mac_out;
    logic              res_valid;
    logic              res_ready = 1'b0;
    logic [DATA_W-1:0] res_data;
    logic              busy;

    int n_checks = 0;
    int n_fail   = 0;

    mac_vector_sequencer #(.DATA_W(DATA_W), .VEC_LEN(VEC_LEN), .MAC_LAT(MAC_LAT)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .mac_reset(mac_reset), .mac_enable(mac_enable),
        .mac_a(mac_a), .mac_b(mac_b), .mac_out(mac_out), .res_valid(res_valid),
        .res_ready(res_ready), .res_data(res_data), .busy(busy)
    );

    always #5 clk = ~clk;

    // Single-stage signed accumulator standing in for the MAC
    logic [DATA_W-1:0] acc_q = '0;
    always @(posedge clk) begin
        if (mac_reset) acc_q <= '0;
        else if (mac_enable) acc_q <= acc_q + DATA_W'($signed(mac_a) * $signed(mac_b));
    end
    assign mac_out = acc_q;

    // Observation of the MAC-side stream plus protocol rules
    int cyc = 0, en_cnt = 0, first_en = 0, rv_rise = 0, hs_cnt = 0, in_cnt = 0;
    int viol_both = 0, viol_accept = 0, viol_hold = 0, proto_cycles = 0;
    logic rv_prev = 1'b0, hold_prev = 1'b0;
    logic [DATA_W-1:0] data_prev = '0;
    logic [DATA_W-1:0] obs_a[$];
    logic [DATA_W-1:0] obs_b[$];

    always @(negedge clk) begin
        cyc     <= cyc + 1;
        rv_prev <= res_valid;
        if (!reset) begin
            en_cnt    <= 0;
            in_cnt    <= 0;
            hold_prev <= 1'b0;
            obs_a.delete();
            obs_b.delete();
        end else begin
            proto_cycles <= proto_cycles + 1;
            if (mac_reset) begin
                en_cnt <= 0;
                in_cnt <= 0;
                obs_a.delete();
                obs_b.delete();
            end
            if (mac_enable) begin
                if (en_cnt == 0) first_en <= cyc;
                en_cnt <= en_cnt + 1;
                obs_a.push_back(mac_a);
                obs_b.push_back(mac_b);
            end
            if (in_valid && in_ready) begin
                if (in_cnt >= VL) viol_accept <= viol_accept + 1;
                in_cnt <= in_cnt + 1;
            end
            if (res_valid && !rv_prev) rv_rise <= cyc;
            if (res_valid && res_ready) hs_cnt <= hs_cnt + 1;
            if (mac_reset && mac_enable) viol_both <= viol_both + 1;
            if (in_ready && (busy || res_valid || mac_enable || mac_reset))
                viol_accept <= viol_accept + 1;
            if (hold_prev && (res_data !== data_prev)) viol_hold <= viol_hold + 1;
            hold_prev <= res_valid && !res_ready;
            data_prev <= res_data;
        end
    end

    function automatic logic [DATA_W-1:0] ref_dot(input int va[VL], input int vb[VL]);
        int s = 0;
        for (int k = 0; k < VL; k++) s += va[k] * vb[k];
        return DATA_W'(s);
    endfunction

    task automatic drive_vec(input int va[VL], input int vb[VL], input int pat[$], input bit rand_gaps);
        int  i = 0;
        int  t = 0;
        bit  took;
        @(posedge clk); #1;
        while (i < VL && t < 200) begin
            if (t < pat.size()) in_valid = (pat[t] != 0);
            else if (rand_gaps) in_valid = ($urandom_range(0, 2) != 0);
            else in_valid = 1'b1;
            in_a = DATA_W'(va[i]);
            in_b = DATA_W'(vb[i]);
            @(negedge clk);
            took = in_valid && in_ready;
            @(posedge clk); #1;
            if (took) i++;
            t++;
        end
        in_valid = 1'b0;
        n_checks++;
        if (i != VL) begin
            n_fail++;
            $display("FAIL load_timeout: accepted %0d pairs, required %0d", i, VL);
        end
    endtask

    task automatic check_result(input string name, input int va[VL], input int vb[VL], input int hold);
        logic [DATA_W-1:0] exp;
        int waited = 0;
        int hs0;
        bit order_ok;
        exp = ref_dot(va, vb);
        res_ready = 1'b0;
        while (waited < 40) begin
            @(negedge clk);
            if (res_valid) break;
            waited++;
        end
        n_checks++;
        if (res_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s res_valid_timeout: res_valid=%b required 1", name, res_valid);
            return;
        end
        #1;
        n_checks++;
        if (rv_rise - first_en != LAT) begin
            n_fail++;
            $display("FAIL %s latency: got %0d cycles, required %0d", name, rv_rise - first_en, LAT);
        end
        n_checks++;
        if (en_cnt != VL) begin
            n_fail++;
            $display("FAIL %s enable_count: got %0d, required %0d", name, en_cnt, VL);
        end
        order_ok = (obs_a.size() == VL) && (obs_b.size() == VL);
        if (order_ok)
            for (int k = 0; k < VL; k++)
                if (obs_a[k] !== DATA_W'(va[k]) || obs_b[k] !== DATA_W'(vb[k])) order_ok = 1'b0;
        n_checks++;
        if (!order_ok) begin
            n_fail++;
            $display("FAIL %s issue_order: issued %0d pairs, required %0d in acceptance order", name, obs_a.size(), VL);
        end
        n_checks++;
        if (res_data !== exp || mac_enable !== 1'b0 || mac_a !== '0 || mac_b !== '0) begin
            n_fail++;
            $display("FAIL %s res_data: got %0d (en=%b a=%h b=%h), required %0d (en=0 a=0 b=0)",
                     name, $signed(res_data), mac_enable, mac_a, mac_b, $signed(exp));
        end
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            @(negedge clk);
            n_checks++;
            if (res_valid !== 1'b1 || res_data !== exp || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL %s hold[%0d]: valid=%b data=%h ready=%b, required 1 %h 0",
                         name, h, res_valid, res_data, in_ready, exp);
            end
        end
        hs0 = hs_cnt;
        @(posedge clk); #1;
        res_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        res_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if (res_valid !== 1'b0 || mac_reset !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s post_handshake: valid=%b mac_reset=%b in_ready=%b, required 0 1 0",
                     name, res_valid, mac_reset, in_ready);
        end
        #1;
        n_checks++;
        if (hs_cnt != hs0 + 1) begin
            n_fail++;
            $display("FAIL %s handshake_count: got %0d, required 1", name, hs_cnt - hs0);
        end
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1 || mac_reset !== 1'b0) begin
            n_fail++;
            $display("FAIL %s reload: in_ready=%b mac_reset=%b, required 1 0", name, in_ready, mac_reset);
        end
    endtask

    task automatic release_and_count(input string name);
        int pulses = 0;
        int waited = 0;
        @(posedge clk); #1;
        reset = 1'b1;
        while (waited < 10) begin
            @(negedge clk);
            if (in_ready) break;
            if (mac_reset) pulses++;
            waited++;
        end
        n_checks++;
        if (in_ready !== 1'b1 || pulses != 1) begin
            n_fail++;
            $display("FAIL %s clear_pulse: in_ready=%b pulses=%0d, required 1 and 1", name, in_ready, pulses);
        end
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if ({in_ready, mac_reset, mac_enable, res_valid, mac_a, mac_b, res_data} !== '0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_values: rdy=%b mr=%b en=%b rv=%b a=%h b=%h d=%h busy=%b, required all 0 busy=1",
                     in_ready, mac_reset, mac_enable, res_valid, mac_a, mac_b, res_data, busy);
        end
        repeat (2) @(posedge clk);
        release_and_count("reset");
    endtask

    task automatic test_basic();
        int va[VL] = '{1, 4, 12, 2};
        int vb[VL] = '{5, 10, 2, 3};
        int none[$];
        drive_vec(va, vb, none, 1'b0);
        check_result("basic", va, vb, 0);
    endtask

    task automatic test_signed();
        int va[VL] = '{1, -1, -1, -20};
        int vb[VL] = '{-1, 1, -2, 2};
        int wa[VL] = '{-7, 0, 0, 0};
        int wb[VL] = '{-2, 0, 0, 0};
        int none[$];
        drive_vec(va, vb, none, 1'b0);
        check_result("signed1", va, vb, 0);
        drive_vec(wa, wb, none, 1'b0);
        check_result("signed2", wa, wb, 1);
    endtask

    task automatic test_wrap();
        int va[VL] = '{127, 1, 0, 0};
        int vb[VL] = '{2, 1, 0, 0};
        int none[$];
        drive_vec(va, vb, none, 1'b0);
        check_result("wrap", va, vb, 0);
    endtask

    task automatic test_stalls();
        int va[VL] = '{1, 4, 12, 2};
        int vb[VL] = '{5, 10, 2, 3};
        int pat[$] = '{1, 0, 0, 1, 0, 1, 1};
        drive_vec(va, vb, pat, 1'b0);
        check_result("stalls", va, vb, 5);
    endtask

    task automatic test_reset_mid_run();
        int va[VL] = '{1, 4, 12, 2};
        int vb[VL] = '{5, 10, 2, 3};
        int ja[VL] = '{9, 9, 9, 9};
        int none[$];
        drive_vec(ja, ja, none, 1'b0);
        @(posedge clk); #1;
        n_checks++;
        if (mac_enable !== 1'b1) begin
            n_fail++;
            $display("FAIL midrun_enable: mac_enable=%b, required 1", mac_enable);
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if ({in_ready, mac_reset, mac_enable, res_valid, mac_a, mac_b, res_data} !== '0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midrun_reset_values: rdy=%b mr=%b en=%b rv=%b a=%h b=%h d=%h busy=%b, required all 0 busy=1",
                     in_ready, mac_reset, mac_enable, res_valid, mac_a, mac_b, res_data, busy);
        end
        repeat (2) @(posedge clk);
        release_and_count("midrun");
        drive_vec(va, vb, none, 1'b0);
        check_result("after_reset", va, vb, 0);
    endtask

    task automatic test_random();
        int va[VL];
        int vb[VL];
        int none[$];
        for (int v = 0; v < 8; v++) begin
            for (int k = 0; k < VL; k++) begin
                va[k] = int'($urandom_range(0, 255)) - 128;
                vb[k] = int'($urandom_range(0, 255)) - 128;
            end
            drive_vec(va, vb, none, 1'b1);
            check_result("random", va, vb, int'($urandom_range(0, 3)));
        end
    endtask

    task automatic test_protocol();
        n_checks++;
        if (viol_both != 0) begin
            n_fail++;
            $display("FAIL proto_reset_enable_overlap: %0d cycles, required 0", viol_both);
        end
        n_checks++;
        if (viol_accept != 0) begin
            n_fail++;
            $display("FAIL proto_accept_outside_load: %0d cycles, required 0", viol_accept);
        end
        n_checks++;
        if (viol_hold != 0 || proto_cycles == 0) begin
            n_fail++;
            $display("FAIL proto_result_hold: %0d changes over %0d cycles, required 0 over >0",
                     viol_hold, proto_cycles);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signed();
        test_wrap();
        test_stalls();
        test_reset_mid_run();
        test_random();
        test_protocol();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
